// File: rtl/memchk_pkg.sv
// Shared types and helpers for the memory result checker.
// The state type is exported so monitors can decode the debug state output.
package memchk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // Widest packed check table the helpers accept: 16 entries of up to 64 bits.
  localparam int MAX_CHECKS = 16;
  localparam int MAX_W      = 64;
  localparam int VEC_W      = MAX_CHECKS * MAX_W;

  // Entry idx of a packed table whose entries are w bits wide (entry 0 in the LSBs).
  // Bits above w are left in place; callers cast the result to w bits.
  function automatic logic [MAX_W-1:0] get_entry(input logic [VEC_W-1:0] vec,
                                                 input int idx, input int w);
    return MAX_W'(vec >> (idx * w));
  endfunction

  function automatic logic [MAX_W-1:0] check_addr(input logic [VEC_W-1:0] addrs,
                                                  input int idx, input int addr_w);
    return get_entry(addrs, idx, addr_w);
  endfunction

  function automatic logic [MAX_W-1:0] check_val(input logic [VEC_W-1:0] vals,
                                                 input int idx, input int xlen);
    return get_entry(vals, idx, xlen);
  endfunction

endpackage

// File: rtl/memchk_channel.sv
// One watched address: compares snooped writes against its address and
// expected value and keeps the per-check hit flag.
// Handshake: none; mem_write_en is a plain strobe sampled on every rising edge,
// there is no ready/back-pressure path toward the memory.
module memchk_channel #(
  parameter int                ADDR_W = 32,
  parameter int                XLEN   = 32,
  parameter logic [ADDR_W-1:0] ADDR   = '0,
  parameter logic [XLEN-1:0]   VAL    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              active,
  input  logic              mem_write_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic              hit,
  output logic              mismatch_now,
  output logic              next_hit
);

  logic addr_match;
  logic data_match;

  // Exact address compare, no alignment masking; only meaningful while running.
  assign addr_match   = active && mem_write_en && (mem_addr == ADDR);
  assign data_match   = (mem_wdata == VAL);
  assign mismatch_now = addr_match && !data_match;

  // Next hit value: cleared on arm, last write to the address wins.
  always_comb begin
    next_hit = hit;
    if (clear) begin
      next_hit = 1'b0;
    end else if (addr_match) begin
      next_hit = data_match;
    end
  end

  // Hit flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit <= 1'b0;
    end else begin
      hit <= next_hit;
    end
  end

endmodule

// File: rtl/mem_result_checker.sv
// Self-check monitor: snoops data-memory writes, compares NUM_CHECKS watched
// addresses against expected values, and reports pass/fail with a timeout.
// Optional error log enabled by defining MEM_RESULT_CHECKER_ERRLOG_EN.
// dbg_state exposes the FSM state for monitors.
module mem_result_checker
  import memchk_pkg::*;
#(
  parameter int                           XLEN           = 32,
  parameter int                           ADDR_W         = 32,
  parameter int                           NUM_CHECKS     = 1,
  parameter logic [NUM_CHECKS*ADDR_W-1:0] CHECK_ADDRS    = '0,
  parameter logic [NUM_CHECKS*XLEN-1:0]   CHECK_VALS     = '0,
  parameter int                           TIMEOUT_CYCLES = 200,
  parameter int                           STRICT         = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              mem_write_en,
  input  logic [ADDR_W-1:0]                 mem_addr,
  input  logic [XLEN-1:0]                   mem_wdata,
  output logic                              done,
  output logic                              pass,
  output logic                              fail,
  output logic [$clog2(NUM_CHECKS+1)-1:0]   fail_idx,
  output logic [NUM_CHECKS-1:0]             hit_mask,
  output logic [31:0]                       cycle_count,
`ifdef MEM_RESULT_CHECKER_ERRLOG_EN
  output logic [ADDR_W-1:0]                 err_addr,
  output logic [XLEN-1:0]                   err_data,
  output logic                              err_valid,
`endif
  output state_t                            dbg_state
);

  localparam int          IDX_W        = $clog2(NUM_CHECKS + 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic                    run_active;
  logic [NUM_CHECKS-1:0]   hit_vec;
  logic [NUM_CHECKS-1:0]   next_hit_vec;
  logic [NUM_CHECKS-1:0]   mismatch_vec;
  logic                    any_mismatch;
  logic [IDX_W-1:0]        first_mismatch;

  assign run_active = (state == ST_RUN);
  assign hit_mask   = hit_vec;
  assign dbg_state  = state;

  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_chan
    localparam logic [ADDR_W-1:0] ADDR_I = ADDR_W'(check_addr(VEC_W'(CHECK_ADDRS), i, ADDR_W));
    localparam logic [XLEN-1:0]   VAL_I  = XLEN'(check_val(VEC_W'(CHECK_VALS), i, XLEN));

    memchk_channel #(
      .ADDR_W (ADDR_W),
      .XLEN   (XLEN),
      .ADDR   (ADDR_I),
      .VAL    (VAL_I)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .clear        (start),
      .active       (run_active),
      .mem_write_en (mem_write_en),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .hit          (hit_vec[i]),
      .mismatch_now (mismatch_vec[i]),
      .next_hit     (next_hit_vec[i])
    );
  end

  // Lowest-index mismatching channel wins the fail index.
  always_comb begin
    any_mismatch   = |mismatch_vec;
    first_mismatch = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (mismatch_vec[i]) begin
        first_mismatch = IDX_W'(i);
      end
    end
  end

  // Checker FSM, run counter and registered verdict outputs.
  // start re-arms from any state; in RUN: strict mismatch > pass > timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cycle_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_idx    <= '0;
    end else if (start) begin
      state       <= ST_RUN;
      cycle_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_idx    <= '0;
    end else if (state == ST_RUN) begin
      cycle_count <= cycle_count + 32'd1;
      if ((STRICT != 0) && any_mismatch) begin
        state    <= ST_FAIL;
        done     <= 1'b1;
        fail     <= 1'b1;
        fail_idx <= first_mismatch;
      end else if (&next_hit_vec) begin
        state <= ST_PASS;
        done  <= 1'b1;
        pass  <= 1'b1;
      end else if (cycle_count == TIMEOUT_LAST) begin
        state    <= ST_FAIL;
        done     <= 1'b1;
        fail     <= 1'b1;
        fail_idx <= IDX_W'(NUM_CHECKS);
      end
    end
  end

`ifdef MEM_RESULT_CHECKER_ERRLOG_EN
  // Capture the first watched-address mismatch of the run; sticky until re-arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr  <= '0;
      err_data  <= '0;
      err_valid <= 1'b0;
    end else if (start) begin
      err_addr  <= '0;
      err_data  <= '0;
      err_valid <= 1'b0;
    end else if (any_mismatch && !err_valid) begin
      err_addr  <= mem_addr;
      err_data  <= mem_wdata;
      err_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_result_checker.sv
// Bench for mem_result_checker: two instances (STRICT=0 and STRICT=1) share
// the same stimulus; directed scenarios plus a randomized run against a
// behavioural model of the checking rules.
module tb_mem_result_checker;
  import memchk_pkg::*;

  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;

  logic        d_done [2];
  logic        d_pass [2];
  logic        d_fail [2];
  logic [1:0]  d_idx  [2];
  logic [1:0]  d_hit  [2];
  logic [31:0] d_cnt  [2];
  state_t      d_st   [2];
`ifdef MEM_RESULT_CHECKER_ERRLOG_EN
  logic [31:0] d_ea [2];
  logic [31:0] d_ed [2];
  logic        d_ev [2];
`endif

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural model: one slot per instance (0 = lenient, 1 = strict).
  int unsigned ca [2] = '{32'd0, 32'd4};
  int unsigned cv [2] = '{32'd55, 32'd89};
  bit          m_run  [2];
  bit          m_done [2];
  bit          m_pass [2];
  bit          m_fail [2];
  int          m_idx  [2];
  int          m_cnt  [2];
  bit          m_hit  [2][2];
  bit          m_ev   [2];
  logic [31:0] m_ea   [2];
  logic [31:0] m_ed   [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_result_checker #(
      .XLEN           (32),
      .ADDR_W         (32),
      .NUM_CHECKS     (2),
      .CHECK_ADDRS    ({32'd4, 32'd0}),
      .CHECK_VALS     ({32'd89, 32'd55}),
      .TIMEOUT_CYCLES (TIMEOUT),
      .STRICT         (k)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mem_write_en (mem_write_en),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .done         (d_done[k]),
      .pass         (d_pass[k]),
      .fail         (d_fail[k]),
      .fail_idx     (d_idx[k]),
      .hit_mask     (d_hit[k]),
      .cycle_count  (d_cnt[k]),
`ifdef MEM_RESULT_CHECKER_ERRLOG_EN
      .err_addr     (d_ea[k]),
      .err_data     (d_ed[k]),
      .err_valid    (d_ev[k]),
`endif
      .dbg_state    (d_st[k])
    );
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_fail[k] = 0;
      m_idx[k] = 0; m_cnt[k] = 0; m_hit[k][0] = 0; m_hit[k][1] = 0;
      m_ev[k] = 0; m_ea[k] = '0; m_ed[k] = '0;
    end
  endtask

  // One clock edge of the checking rules for both instances.
  task automatic model_step(input bit st, input bit we, input logic [31:0] a, input logic [31:0] d);
    int low;
    for (int k = 0; k < 2; k++) begin
      if (st) begin
        m_run[k] = 1; m_done[k] = 0; m_pass[k] = 0; m_fail[k] = 0;
        m_idx[k] = 0; m_cnt[k] = 0; m_hit[k][0] = 0; m_hit[k][1] = 0;
        m_ev[k] = 0; m_ea[k] = '0; m_ed[k] = '0;
      end else if (m_run[k]) begin
        m_cnt[k] = m_cnt[k] + 1;
        low = -1;
        for (int i = 0; i < 2; i++) begin
          if (we && a == ca[i]) begin
            if (d == cv[i]) m_hit[k][i] = 1;
            else begin
              m_hit[k][i] = 0;
              if (low < 0) low = i;
            end
          end
        end
        if (low >= 0 && !m_ev[k]) begin
          m_ev[k] = 1; m_ea[k] = a; m_ed[k] = d;
        end
        if (k == 1 && low >= 0) begin
          m_run[k] = 0; m_done[k] = 1; m_fail[k] = 1; m_idx[k] = low;
        end else if (m_hit[k][0] && m_hit[k][1]) begin
          m_run[k] = 0; m_done[k] = 1; m_pass[k] = 1;
        end else if (m_cnt[k] == TIMEOUT) begin
          m_run[k] = 0; m_done[k] = 1; m_fail[k] = 1; m_idx[k] = 2;
        end
      end
    end
  endtask

  function automatic state_t model_state(input int k);
    if (m_run[k]) return ST_RUN;
    if (m_pass[k]) return ST_PASS;
    if (m_fail[k]) return ST_FAIL;
    return ST_IDLE;
  endfunction

  // Drive one cycle at the falling edge, sample #1 after the rising edge.
  task automatic tick(input bit st, input bit we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    start = st; mem_write_en = we; mem_addr = a; mem_wdata = d;
    @(posedge clk);
    model_step(st, we, a, d);
    #1;
    start = 1'b0; mem_write_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      if (d_done[k] !== 1'b0) begin n_mis++; $display("FAIL reset_done[%0d]: got %0b expected 0", k, d_done[k]); end
      n_cmp++;
      if (d_pass[k] !== 1'b0 || d_fail[k] !== 1'b0) begin n_mis++; $display("FAIL reset_verdict[%0d]: got pass=%0b fail=%0b expected 0/0", k, d_pass[k], d_fail[k]); end
      n_cmp++;
      if (d_idx[k] !== 2'd0 || d_hit[k] !== 2'b00 || d_cnt[k] !== 32'd0) begin n_mis++; $display("FAIL reset_regs[%0d]: got idx=%0d hit=%b cnt=%0d expected 0", k, d_idx[k], d_hit[k], d_cnt[k]); end
      n_cmp++;
      if (d_st[k] !== ST_IDLE) begin n_mis++; $display("FAIL reset_state[%0d]: got %0d expected %0d", k, d_st[k], ST_IDLE); end
      n_cmp++;
`ifdef MEM_RESULT_CHECKER_ERRLOG_EN
      if (d_ev[k] !== 1'b0 || d_ea[k] !== 32'd0 || d_ed[k] !== 32'd0) begin n_mis++; $display("FAIL reset_errlog[%0d]: got v=%0b a=%0d d=%0d expected 0", k, d_ev[k], d_ea[k], d_ed[k]); end
      n_cmp++;
`endif
    end
  endtask

  task automatic test_pass();
    tick(1, 0, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      if (c == 10) tick(0, 1, 32'd0, 32'd55);
      else if (c == 20) tick(0, 1, 32'd4, 32'd89);
      else tick(0, 0, 32'd0, 32'd0);
      if (c == 19) begin
        if (d_done[0] !== 1'b0 || d_hit[0] !== 2'b01) begin n_mis++; $display("FAIL pass_pre: got done=%0b hit=%b expected 0/01", d_done[0], d_hit[0]); end
        n_cmp++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (d_pass[k] !== 1'b1 || d_done[k] !== 1'b1 || d_fail[k] !== 1'b0) begin n_mis++; $display("FAIL pass_flags[%0d]: got p=%0b d=%0b f=%0b expected 1/1/0", k, d_pass[k], d_done[k], d_fail[k]); end
      n_cmp++;
      if (d_hit[k] !== 2'b11 || d_cnt[k] !== 32'd20) begin n_mis++; $display("FAIL pass_hit_cnt[%0d]: got hit=%b cnt=%0d expected 11/20", k, d_hit[k], d_cnt[k]); end
      n_cmp++;
    end
    for (int c = 0; c < 5; c++) tick(0, 1, 32'd0, 32'd1);
    if (d_cnt[0] !== 32'd20 || d_hit[0] !== 2'b11 || d_st[0] !== ST_PASS) begin n_mis++; $display("FAIL pass_frozen: got cnt=%0d hit=%b st=%0d expected 20/11/%0d", d_cnt[0], d_hit[0], d_st[0], ST_PASS); end
    n_cmp++;
  endtask

  task automatic test_rearm();
    tick(1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      if (d_done[k] !== 1'b0 || d_pass[k] !== 1'b0 || d_hit[k] !== 2'b00 || d_cnt[k] !== 32'd0 || d_st[k] !== ST_RUN) begin
        n_mis++; $display("FAIL rearm_clear[%0d]: got d=%0b p=%0b hit=%b cnt=%0d st=%0d expected 0/0/00/0/RUN", k, d_done[k], d_pass[k], d_hit[k], d_cnt[k], d_st[k]);
      end
      n_cmp++;
    end
    tick(0, 1, 32'd4, 32'd89);
    if (d_hit[0] !== 2'b10 || d_pass[0] !== 1'b0 || d_cnt[0] !== 32'd1) begin n_mis++; $display("FAIL rearm_no_carry: got hit=%b pass=%0b cnt=%0d expected 10/0/1", d_hit[0], d_pass[0], d_cnt[0]); end
    n_cmp++;
  endtask

  task automatic test_last_write_strict_timeout();
    tick(1, 0, 0, 0);
    tick(0, 1, 32'd0, 32'd34);
    if (d_fail[1] !== 1'b1 || d_done[1] !== 1'b1 || d_idx[1] !== 2'd0 || d_cnt[1] !== 32'd1) begin n_mis++; $display("FAIL strict_fail: got f=%0b d=%0b idx=%0d cnt=%0d expected 1/1/0/1", d_fail[1], d_done[1], d_idx[1], d_cnt[1]); end
    n_cmp++;
    if (d_fail[0] !== 1'b0 || d_hit[0] !== 2'b00) begin n_mis++; $display("FAIL lenient_no_fail: got f=%0b hit=%b expected 0/00", d_fail[0], d_hit[0]); end
    n_cmp++;
`ifdef MEM_RESULT_CHECKER_ERRLOG_EN
    for (int k = 0; k < 2; k++) begin
      if (d_ev[k] !== 1'b1 || d_ea[k] !== 32'd0 || d_ed[k] !== 32'd34) begin n_mis++; $display("FAIL errlog[%0d]: got v=%0b a=%0d d=%0d expected 1/0/34", k, d_ev[k], d_ea[k], d_ed[k]); end
      n_cmp++;
    end
`endif
    tick(0, 1, 32'd0, 32'd55);
    if (d_hit[0] !== 2'b01) begin n_mis++; $display("FAIL last_write_wins: got hit=%b expected 01", d_hit[0]); end
    n_cmp++;
    for (int c = 3; c < TIMEOUT; c++) tick(0, 0, 32'd0, 32'd0);
    if (d_fail[0] !== 1'b0 || d_cnt[0] !== 32'd199) begin n_mis++; $display("FAIL timeout_early: got f=%0b cnt=%0d expected 0/199", d_fail[0], d_cnt[0]); end
    n_cmp++;
    tick(0, 0, 32'd0, 32'd0);
    if (d_fail[0] !== 1'b1 || d_idx[0] !== 2'd2 || d_cnt[0] !== 32'd200 || d_hit[0] !== 2'b01) begin n_mis++; $display("FAIL timeout: got f=%0b idx=%0d cnt=%0d hit=%b expected 1/2/200/01", d_fail[0], d_idx[0], d_cnt[0], d_hit[0]); end
    n_cmp++;
    if (d_cnt[1] !== 32'd1 || d_idx[1] !== 2'd0) begin n_mis++; $display("FAIL strict_frozen: got cnt=%0d idx=%0d expected 1/0", d_cnt[1], d_idx[1]); end
    n_cmp++;
  endtask

  task automatic test_pass_beats_timeout();
    tick(1, 0, 0, 0);
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (c == 5) tick(0, 1, 32'd0, 32'd55);
      else if (c == TIMEOUT) tick(0, 1, 32'd4, 32'd89);
      else tick(0, 0, 32'd0, 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      if (d_pass[k] !== 1'b1 || d_fail[k] !== 1'b0 || d_cnt[k] !== 32'd200) begin n_mis++; $display("FAIL pass_beats_timeout[%0d]: got p=%0b f=%0b cnt=%0d expected 1/0/200", k, d_pass[k], d_fail[k], d_cnt[k]); end
      n_cmp++;
    end
  endtask

  task automatic test_start_in_run();
    tick(1, 0, 0, 0);
    tick(0, 1, 32'd0, 32'd55);
    for (int c = 0; c < 4; c++) tick(0, 0, 32'd0, 32'd0);
    tick(1, 1, 32'd4, 32'd89);
    if (d_cnt[0] !== 32'd0 || d_hit[0] !== 2'b00 || d_st[0] !== ST_RUN) begin n_mis++; $display("FAIL restart: got cnt=%0d hit=%b st=%0d expected 0/00/RUN", d_cnt[0], d_hit[0], d_st[0]); end
    n_cmp++;
    tick(0, 1, 32'd4, 32'd89);
    if (d_hit[0] !== 2'b10 || d_pass[0] !== 1'b0) begin n_mis++; $display("FAIL restart_hits: got hit=%b pass=%0b expected 10/0", d_hit[0], d_pass[0]); end
    n_cmp++;
  endtask

  task automatic test_reset_mid_run();
    tick(1, 0, 0, 0);
    for (int c = 1; c <= 50; c++) tick(0, c == 7, 32'd0, 32'd55);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (d_done[k] !== 1'b0 || d_hit[k] !== 2'b00 || d_cnt[k] !== 32'd0 || d_st[k] !== ST_IDLE) begin n_mis++; $display("FAIL async_reset[%0d]: got d=%0b hit=%b cnt=%0d st=%0d expected 0/00/0/IDLE", k, d_done[k], d_hit[k], d_cnt[k], d_st[k]); end
      n_cmp++;
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(0, 1, 32'd0, 32'd55);
    tick(0, 1, 32'd4, 32'd89);
    tick(0, 1, 32'd0, 32'd34);
    for (int k = 0; k < 2; k++) begin
      if (d_hit[k] !== 2'b00 || d_done[k] !== 1'b0 || d_cnt[k] !== 32'd0 || d_st[k] !== ST_IDLE) begin n_mis++; $display("FAIL idle_ignore[%0d]: got hit=%b d=%0b cnt=%0d st=%0d expected 00/0/0/IDLE", k, d_hit[k], d_done[k], d_cnt[k], d_st[k]); end
      n_cmp++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    bit          st;
    bit          we;
    do_reset();
    tick(1, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      st = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: a = 32'd0;
        1: a = 32'd4;
        2: a = 32'd8;
        3: a = 32'd1;
        default: a = 32'hFFFF_FFFC;
      endcase
      case ($urandom_range(0, 3))
        0: d = 32'd55;
        1: d = 32'd89;
        2: d = 32'd34;
        default: d = $urandom;
      endcase
      tick(st, we, a, d);
      for (int k = 0; k < 2; k++) begin
        if (d_done[k] !== m_done[k] || d_pass[k] !== m_pass[k] || d_fail[k] !== m_fail[k]) begin
          n_mis++; $display("FAIL rnd_flags[%0d] n=%0d: got d=%0b p=%0b f=%0b expected %0b/%0b/%0b", k, n, d_done[k], d_pass[k], d_fail[k], m_done[k], m_pass[k], m_fail[k]);
        end
        n_cmp++;
        if (d_hit[k] !== {m_hit[k][1], m_hit[k][0]} || d_cnt[k] !== 32'(m_cnt[k]) || d_idx[k] !== 2'(m_idx[k])) begin
          n_mis++; $display("FAIL rnd_regs[%0d] n=%0d: got hit=%b cnt=%0d idx=%0d expected %b%b/%0d/%0d", k, n, d_hit[k], d_cnt[k], d_idx[k], m_hit[k][1], m_hit[k][0], m_cnt[k], m_idx[k]);
        end
        n_cmp++;
        if (d_st[k] !== model_state(k)) begin n_mis++; $display("FAIL rnd_state[%0d] n=%0d: got %0d expected %0d", k, n, d_st[k], model_state(k)); end
        n_cmp++;
`ifdef MEM_RESULT_CHECKER_ERRLOG_EN
        if (d_ev[k] !== m_ev[k] || d_ea[k] !== m_ea[k] || d_ed[k] !== m_ed[k]) begin
          n_mis++; $display("FAIL rnd_errlog[%0d] n=%0d: got v=%0b a=%0h d=%0h expected %0b/%0h/%0h", k, n, d_ev[k], d_ea[k], d_ed[k], m_ev[k], m_ea[k], m_ed[k]);
        end
        n_cmp++;
`endif
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pass();
    test_rearm();
    test_last_write_strict_timeout();
    test_pass_beats_timeout();
    test_start_in_run();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_result_checker.md
# mem_result_checker

- Synthesizable self-check monitor for CPU program tests.
- Snoops the data-memory write port and compares writes to NUM_CHECKS watched addresses against expected values.
- Raises pass/fail with a cycle-count timeout.
- Replaces hard-coded post-run memory peeks in benches with an in-design, any-width, multi-result checker usable in simulation and on FPGA.

## Interface

Parameters:

- XLEN, 32, data width of snooped write data
- ADDR_W, 32, width of snooped byte address
- NUM_CHECKS, 1, number of watched address/expected-value pairs (1..16)
- CHECK_ADDRS, '0, packed NUM_CHECKS×ADDR_W; entry i = byte address of check i
- CHECK_VALS, '0, packed NUM_CHECKS×XLEN; entry i = expected value of check i
- TIMEOUT_CYCLES, 200, RUN cycles before timeout failure (≥1)
- STRICT, 0, 1 = any wrong write to a watched address fails immediately

Ports:

- clk in 1: rising-edge clock
- rst in 1: asynchronous, active-high reset
- start in 1: single-cycle pulse that arms or re-arms the checker
- mem_write_en in 1: data-memory write strobe (snooped)
- mem_addr in ADDR_W: data-memory byte address (snooped)
- mem_wdata in XLEN: data-memory write data (snooped)
- done out 1: checker is in PASS or FAIL
- pass out 1: all checks matched before timeout
- fail out 1: timeout, or strict mismatch
- fail_idx out $clog2(NUM_CHECKS+1): failing check index; value NUM_CHECKS = timeout
- hit_mask out NUM_CHECKS: per-check match status
- cycle_count out 32: RUN cycles elapsed; frozen once done

## Operation

FSM states: IDLE, RUN, PASS, FAIL.

- IDLE: hit_mask cleared, counter held at 0. start → RUN.
- RUN: cycle_count increments every cycle. When mem_write_en is high, each channel i compares mem_addr to CHECK_ADDRS[i].
  - Address match and data == CHECK_VALS[i]: set hit[i].
  - Address match and data mismatch, STRICT=0: clear hit[i]. Last write wins.
  - Address match and data mismatch, STRICT=1: go to FAIL, fail_idx = lowest mismatching i.
- PASS: entered on the edge where the next-state hit_mask becomes all ones.
- FAIL on timeout: entered on the edge where cycle_count reaches TIMEOUT_CYCLES−1 and PASS is not taken. fail_idx = NUM_CHECKS.
- PASS and FAIL are terminal. Outputs hold until start (re-arm: clear hit_mask, counter and fail_idx, go to RUN) or rst.
- Priority within one edge: strict mismatch > pass > timeout.
- start while in RUN restarts the run (counter and hits cleared) and takes priority over all RUN transitions.
- Duplicate CHECK_ADDRS entries: both channels evaluate independently.
- Addresses compare exactly, with no alignment masking.

## Timing

- Reset values: done=0, pass=0, fail=0, fail_idx=0, hit_mask=0, cycle_count=0, state IDLE.
- rst asserted mid-run returns to IDLE immediately (asynchronous). No pass/fail is reported for the interrupted run.
- Zero-latency decision: the write sampled on edge N updates hit_mask, pass/fail and done on that same edge N. They are visible right after edge N.
- cycle_count = number of RUN-state edges taken.
  - A start pulse sampled at edge S gives cycle_count=1 after edge S+1.
  - The timeout edge leaves cycle_count = TIMEOUT_CYCLES.
- mem_* inputs are ignored outside RUN.

## Configuration

- MEM_RESULT_CHECKER_ERRLOG_EN defined:
  - Adds outputs err_addr (ADDR_W) and err_data (XLEN), both reset 0.
  - They capture the address and data of the first watched-address mismatch in the run, in either STRICT mode.
  - Adds output err_valid (1), sticky until start/rst.
- Not defined: these ports and registers do not exist. All other behaviour is identical.

## Structure

- memchk_pkg holds:
  - the state enum (IDLE/RUN/PASS/FAIL)
  - helper functions to extract entry i from CHECK_ADDRS/CHECK_VALS
- One sub-module, memchk_channel, instantiated NUM_CHECKS times via generate:
  - contains the address/data comparators and the hit flip-flop
  - outputs hit, mismatch_now and next_hit
- Top level holds the FSM, the cycle counter, fail_idx priority encoding and the optional error log.

## Test plan

All scenarios use NUM_CHECKS=2, CHECK_ADDRS={4,0}, CHECK_VALS={89,55}, TIMEOUT_CYCLES=200 unless stated.

- Pass, same-cycle flags: start; write 0←55 at cycle 10, 4←89 at cycle 20 → pass=1 and done=1 after the cycle-20 edge; hit_mask=2'b11; cycle_count frozen at 20.
- Last write wins, and timeout: STRICT=0; write 0←34 then 0←55, then no write to 4 → hit[0]=1, hit[1]=0; at cycle 200 fail=1, fail_idx=2, cycle_count=200.
- Strict mismatch: STRICT=1; write 0←34 → fail=1, fail_idx=0 on that edge. With MEM_RESULT_CHECKER_ERRLOG_EN: err_addr=0, err_data=34, err_valid=1.
- Pass beats timeout: final matching write on edge 200 → pass=1, fail=0.
- Re-arm: pulse start while in PASS → outputs cleared, RUN entered; the previous hits do not carry over.
- Reset mid-run: assert rst at cycle 50 between clock edges → all outputs 0 immediately, state IDLE; writes before the next start are ignored.
